// File: rtl/ysyx_22040127_dcache.sv
// Direct-mapped write-through, no-write-allocate data cache, 8-byte lines.
// Define YSYX_DCACHE_MMIO_BYPASS_EN to treat req_addr[31:28]==4'ha as uncached.
module ysyx_22040127_dcache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [7:0]  req_wmask,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    input  logic        inv,
    output logic [2:0]  cache_state,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata
);
    localparam int TAG_BITS = 61 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        WR_REQ    = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t              state;
    logic [63:3]         addr_q;
    logic [7:0]          wmask_q;
    logic [63:0]         wdata_q;
    logic [63:0]         rdata_q;
    logic                write_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [63:0]         data_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  cacheable;
    logic                  hit;
    logic                  load_hit;
    logic [63:0]           wdata_rep;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[2:0];
    assign idx = addr_q[3 +: INDEX_BITS];
    assign tag = addr_q[63 -: TAG_BITS];

`ifdef YSYX_DCACHE_MMIO_BYPASS_EN
    assign cacheable = (addr_q[31:28] != 4'ha);
`else
    assign cacheable = 1'b1;
`endif

    assign hit      = cacheable && valid_q[idx] && (tag_q[idx] == tag);
    assign load_hit = (state == LOOKUP) && !write_q && hit;

    always_comb begin
        wdata_rep = req_wdata;
        unique case (req_size)
            2'b00: wdata_rep = {8{req_wdata[7:0]}};
            2'b01: wdata_rep = {4{req_wdata[15:0]}};
            2'b10: wdata_rep = {2{req_wdata[31:0]}};
            2'b11: wdata_rep = req_wdata;
        endcase
    end

    assign req_ready     = (state == IDLE);
    assign cache_state   = state;
    assign mem_req_valid = (state == MISS_REQ) || (state == WR_REQ);
    assign mem_req_write = (state == WR_REQ);
    assign mem_req_addr  = {addr_q, 3'b000};
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = (state == MISS_REQ) ? 8'hff : wmask_q;
    assign resp_valid    = load_hit || (state == RESP);

    always_comb begin
        resp_rdata = '0;
        if (load_hit)
            resp_rdata = data_q[idx];
        else if (state == RESP && !write_q)
            resp_rdata = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= '0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inv) begin
                        valid_q <= '0;
                    end else if (req_valid) begin
                        addr_q  <= req_addr[63:3];
                        wmask_q <= req_wmask;
                        wdata_q <= wdata_rep;
                        write_q <= req_write;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (write_q) begin
                        // write-through: merge on hit, never allocate on miss
                        if (hit) begin
                            for (int i = 0; i < 8; i++)
                                if (wmask_q[i])
                                    data_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                        end
                        state <= WR_REQ;
                    end else if (hit) begin
                        state <= IDLE;
                    end else begin
                        state <= MISS_REQ;
                    end
                end
                MISS_REQ: if (mem_req_ready) state <= MISS_WAIT;
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        if (cacheable) begin
                            data_q[idx]  <= mem_resp_rdata;
                            tag_q[idx]   <= tag;
                            valid_q[idx] <= 1'b1;
                        end
                        rdata_q <= mem_resp_rdata;
                        state   <= RESP;
                    end
                end
                WR_REQ: if (mem_req_ready) state <= RESP;
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040127_dcache.sv
// Directed self-checking bench for ysyx_22040127_dcache.
// Memory side is driven inline by the transaction task.
module tb_ysyx_22040127_dcache;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [7:0]  req_wmask;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        inv;
    logic [2:0]  cache_state;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    int checks = 0;
    int failures = 0;

    logic        last_write;
    logic [63:0] last_addr, last_wdata;
    logic [7:0]  last_wmask;
    logic [7:0]  seen_states;

    logic        got;
    logic [63:0] rd;
    int          lat, nmem;

    ysyx_22040127_dcache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_wmask(req_wmask),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .inv(inv), .cache_state(cache_state),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one request from IDLE at a negedge and plays memory.
    task automatic txn(
        input  logic        wr,
        input  logic [63:0] addr,
        input  logic [1:0]  size,
        input  logic [7:0]  wm,
        input  logic [63:0] wd,
        input  logic [63:0] mdata,
        input  int          stall,
        input  int          rdelay,
        output logic        o_got,
        output logic [63:0] o_rd,
        output int          o_lat,
        output int          o_nmem
    );
        int acc_at;
        int stalled;
        acc_at = -1; stalled = 0;
        o_got = 1'b0; o_rd = '0; o_lat = -1; o_nmem = 0;
        seen_states = '0;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_size = size; req_wmask = wm; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 60 && !o_got; k++) begin
            seen_states[cache_state] = 1'b1;
            mem_resp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (acc_at >= 0 && !wr && k == acc_at + rdelay) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = mdata;
            end
            if (mem_req_valid && acc_at < 0) begin
                if (stalled >= stall) begin
                    mem_req_ready = 1'b1;
                    acc_at = k;
                    o_nmem++;
                    last_write = mem_req_write;
                    last_addr = mem_req_addr;
                    last_wdata = mem_req_wdata;
                    last_wmask = mem_req_wmask;
                end else begin
                    stalled++;
                end
            end
            if (resp_valid) begin
                o_got = 1'b1; o_rd = resp_rdata; o_lat = k;
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (cache_state !== 3'd0 || resp_valid !== 1'b0 ||
            resp_rdata !== 64'h0 || mem_req_valid !== 1'b0 ||
            mem_req_write !== 1'b0) begin
            $display("FAIL reset_ctl state=%0d rv=%b rd=%h mv=%b mw=%b exp 0",
                     cache_state, resp_valid, resp_rdata,
                     mem_req_valid, mem_req_write);
            failures++;
        end
        checks++;
        if (mem_req_addr !== 64'h0 || mem_req_wdata !== 64'h0 ||
            mem_req_wmask !== 8'h0 || req_ready !== 1'b1) begin
            $display("FAIL reset_data addr=%h wd=%h wm=%h rdy=%b exp 0/0/0/1",
                     mem_req_addr, mem_req_wdata, mem_req_wmask, req_ready);
            failures++;
        end
    endtask

    task automatic test_load_miss_hit();
        txn(0, 64'h80000010, 2'b11, 8'h0, 64'h0,
            64'h1122334455667788, 0, 3, got, rd, lat, nmem);
        checks++;
        if (!got || rd !== 64'h1122334455667788 || lat != 6) begin
            $display("FAIL miss_load got=%b rd=%h lat=%0d exp 1/1122334455667788/6",
                     got, rd, lat);
            failures++;
        end
        checks++;
        if (nmem != 1 || last_write !== 1'b0 ||
            last_addr !== 64'h80000010 || last_wmask !== 8'hff) begin
            $display("FAIL miss_memreq n=%0d w=%b a=%h m=%h exp 1/0/80000010/ff",
                     nmem, last_write, last_addr, last_wmask);
            failures++;
        end
        txn(0, 64'h80000010, 2'b11, 8'h0, 64'h0,
            64'hdeaddeaddeaddead, 0, 3, got, rd, lat, nmem);
        checks++;
        if (!got || rd !== 64'h1122334455667788 || lat != 1 || nmem != 0) begin
            $display("FAIL hit_load got=%b rd=%h lat=%0d n=%0d exp 1/1122334455667788/1/0",
                     got, rd, lat, nmem);
            failures++;
        end
    endtask

    task automatic test_store_hit();
        txn(1, 64'h80000013, 2'b00, 8'h08, 64'h00000000000000ab,
            64'h0, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || rd !== 64'h0 || lat != 3 || nmem != 1) begin
            $display("FAIL sb_resp got=%b rd=%h lat=%0d n=%0d exp 1/0/3/1",
                     got, rd, lat, nmem);
            failures++;
        end
        checks++;
        if (last_write !== 1'b1 || last_addr !== 64'h80000010 ||
            last_wdata !== 64'habababababababab || last_wmask !== 8'h08) begin
            $display("FAIL sb_memreq w=%b a=%h d=%h m=%h exp 1/80000010/abab../08",
                     last_write, last_addr, last_wdata, last_wmask);
            failures++;
        end
        txn(0, 64'h80000010, 2'b11, 8'h0, 64'h0,
            64'h0, 0, 3, got, rd, lat, nmem);
        checks++;
        if (!got || rd !== 64'h11223344ab667788 || lat != 1 || nmem != 0) begin
            $display("FAIL sb_merge got=%b rd=%h lat=%0d n=%0d exp 1/11223344ab667788/1/0",
                     got, rd, lat, nmem);
            failures++;
        end
    endtask

    task automatic test_store_miss();
        txn(1, 64'h80000400, 2'b10, 8'hf0, 64'h00000000deadbeef,
            64'h0, 1, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || last_write !== 1'b1 ||
            last_addr !== 64'h80000400 ||
            last_wdata !== 64'hdeadbeefdeadbeef || last_wmask !== 8'hf0) begin
            $display("FAIL sw_miss got=%b n=%0d w=%b a=%h d=%h m=%h exp 1/1/1/80000400/deadbeefdeadbeef/f0",
                     got, nmem, last_write, last_addr, last_wdata, last_wmask);
            failures++;
        end
        txn(0, 64'h80000400, 2'b11, 8'h0, 64'h0,
            64'h0badf00d0badf00d, 0, 2, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || rd !== 64'h0badf00d0badf00d) begin
            $display("FAIL no_alloc got=%b n=%0d rd=%h exp 1/1/0badf00d0badf00d",
                     got, nmem, rd);
            failures++;
        end
    endtask

    task automatic test_conflict_inv();
        txn(0, 64'h80000010, 2'b11, 8'h0, 64'h0,
            64'h0, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || lat != 1 || nmem != 0) begin
            $display("FAIL conf_pre got=%b lat=%0d n=%0d exp 1/1/0", got, lat, nmem);
            failures++;
        end
        txn(0, 64'h80000210, 2'b11, 8'h0, 64'h0,
            64'h2222222222222222, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || rd !== 64'h2222222222222222) begin
            $display("FAIL conf_fill got=%b n=%0d rd=%h exp 1/1/2222..", got, nmem, rd);
            failures++;
        end
        txn(0, 64'h80000210, 2'b11, 8'h0, 64'h0,
            64'h0, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || lat != 1 || nmem != 0 || rd !== 64'h2222222222222222) begin
            $display("FAIL conf_hit got=%b lat=%0d n=%0d rd=%h exp 1/1/0/2222..",
                     got, lat, nmem, rd);
            failures++;
        end
        txn(0, 64'h80000010, 2'b11, 8'h0, 64'h0,
            64'h1010101010101010, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || rd !== 64'h1010101010101010) begin
            $display("FAIL conf_evict got=%b n=%0d rd=%h exp 1/1/1010..", got, nmem, rd);
            failures++;
        end
        txn(0, 64'h80000210, 2'b11, 8'h0, 64'h0,
            64'h2323232323232323, 0, 1, got, rd, lat, nmem);
        inv = 1'b1; req_valid = 1'b1; req_write = 1'b0;
        req_addr = 64'h80000210;
        @(negedge clk);
        checks++;
        if (cache_state !== 3'd0 || req_ready !== 1'b1) begin
            $display("FAIL inv_idle state=%0d rdy=%b exp 0/1", cache_state, req_ready);
            failures++;
        end
        inv = 1'b0; req_valid = 1'b0;
        txn(0, 64'h80000210, 2'b11, 8'h0, 64'h0,
            64'h3333333333333333, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || rd !== 64'h3333333333333333) begin
            $display("FAIL inv_miss got=%b n=%0d rd=%h exp 1/1/3333..", got, nmem, rd);
            failures++;
        end
    endtask

    task automatic test_backpressure_reset();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h80000020;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cache_state !== 3'd2 || mem_req_valid !== 1'b1 ||
                mem_req_write !== 1'b0 || mem_req_addr !== 64'h80000020 ||
                mem_req_wmask !== 8'hff) begin
                $display("FAIL bp_hold[%0d] st=%0d v=%b w=%b a=%h m=%h exp 2/1/0/80000020/ff",
                         i, cache_state, mem_req_valid, mem_req_write,
                         mem_req_addr, mem_req_wmask);
                failures++;
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cache_state !== 3'd0 || mem_req_valid !== 1'b0 ||
            resp_valid !== 1'b0 || mem_req_addr !== 64'h0) begin
            $display("FAIL bp_reset st=%0d v=%b rv=%b a=%h exp 0/0/0/0",
                     cache_state, mem_req_valid, resp_valid, mem_req_addr);
            failures++;
        end
        rst = 1'b0;
        @(negedge clk);
        txn(0, 64'h80000210, 2'b11, 8'h0, 64'h0,
            64'h4444444444444444, 2, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || lat != 6 || rd !== 64'h4444444444444444) begin
            $display("FAIL rst_inval got=%b n=%0d lat=%0d rd=%h exp 1/1/6/4444..",
                     got, nmem, lat, rd);
            failures++;
        end
    endtask

    task automatic test_mmio();
`ifdef YSYX_DCACHE_MMIO_BYPASS_EN
        txn(0, 64'ha00003f8, 2'b11, 8'h0, 64'h0,
            64'h5555555555555555, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || rd !== 64'h5555555555555555 ||
            seen_states[2] !== 1'b1 || seen_states[3] !== 1'b1 ||
            seen_states[5] !== 1'b1) begin
            $display("FAIL mmio_1 got=%b n=%0d rd=%h seen=%b exp 1/1/5555../bits2,3,5",
                     got, nmem, rd, seen_states);
            failures++;
        end
        txn(0, 64'ha00003f8, 2'b11, 8'h0, 64'h0,
            64'h6666666666666666, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 1 || rd !== 64'h6666666666666666 ||
            seen_states[2] !== 1'b1 || seen_states[3] !== 1'b1 ||
            seen_states[5] !== 1'b1) begin
            $display("FAIL mmio_2 got=%b n=%0d rd=%h seen=%b exp 1/1/6666../bits2,3,5",
                     got, nmem, rd, seen_states);
            failures++;
        end
`else
        txn(0, 64'ha00003f8, 2'b11, 8'h0, 64'h0,
            64'h5555555555555555, 0, 1, got, rd, lat, nmem);
        txn(0, 64'ha00003f8, 2'b11, 8'h0, 64'h0,
            64'h6666666666666666, 0, 1, got, rd, lat, nmem);
        checks++;
        if (!got || nmem != 0 || lat != 1 || rd !== 64'h5555555555555555) begin
            $display("FAIL mmio_cached got=%b n=%0d lat=%0d rd=%h exp 1/0/1/5555..",
                     got, nmem, lat, rd);
            failures++;
        end
`endif
    endtask

    initial begin
        rst = 1'b1; inv = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 2'b11; req_wmask = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        last_write = 1'b0; last_addr = '0; last_wdata = '0; last_wmask = '0;
        seen_states = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_load_miss_hit();
        test_store_hit();
        test_store_miss();
        test_conflict_inv();
        test_backpressure_reset();
        test_mmio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
